idecode_execute_memory: RTL and testbench



---
 rtl/idecode_execute_memory.sv | 215 +++++++++++++++++++++
 tb/tb_idecode_execute_memory.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/idecode_execute_memory.sv
// Decode, execute and memory stages of the MIPS-subset pipeline,
// including the ID/EX, EX/MEM and MEM/WB registers.
module idecode_execute_memory (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_ID_instr,
    input  logic [31:0] IF_ID_npc,
    input  logic [31:0] WB_mux_writedata,
    output logic        EX_MEM_PCSrc,
    output logic [31:0] EX_MEM_NPC,
    output logic        MEM_WB_regwrite,
    output logic        MEM_WB_memtoreg,
    output logic [4:0]  MEM_WB_rd,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result
);

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        regdst;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [31:0] npc;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } id_ex_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic        branch;
        logic        memread;
        logic        memwrite;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] rdata2;
        logic [31:0] target;
        logic [4:0]  dest;
    } ex_mem_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] rdata;
        logic [31:0] alu_result;
        logic [4:0]  dest;
    } mem_wb_t;

    id_ex_t  id_ex, id_next;
    ex_mem_t ex_mem, ex_next;
    mem_wb_t mem_wb, wb_next;

    logic [31:0] regs [32];
    logic [31:0] dmem [256];

    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic        regdst, alusrc, branch, memread, memwrite;
    logic        regwrite, memtoreg;
    logic [1:0]  aluop;
    logic        wb_en;

    assign opcode = IF_ID_instr[31:26];
    assign rs     = IF_ID_instr[25:21];
    assign rt     = IF_ID_instr[20:16];
    assign wb_en  = MEM_WB_regwrite && (MEM_WB_rd != 5'd0);

    always_comb begin
        regdst   = 1'b0;
        alusrc   = 1'b0;
        aluop    = 2'b00;
        branch   = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        case (opcode)
            6'h00: begin
                regdst   = 1'b1;
                aluop    = 2'b10;
                regwrite = 1'b1;
            end
            6'h23: begin
                alusrc   = 1'b1;
                memread  = 1'b1;
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            6'h2B: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            6'h04: begin
                aluop  = 2'b01;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Reads see a same-edge writeback so ID never captures stale data
    always_comb begin
        id_next        = '0;
        id_next.wb     = {regwrite, memtoreg};
        id_next.m      = {branch, memread, memwrite};
        id_next.regdst = regdst;
        id_next.alusrc = alusrc;
        id_next.aluop  = aluop;
        id_next.npc    = IF_ID_npc;
        id_next.sext   = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};
        id_next.rt     = rt;
        id_next.rd     = IF_ID_instr[15:11];
        if (rs == 5'd0)
            id_next.rdata1 = '0;
        else if (wb_en && MEM_WB_rd == rs)
            id_next.rdata1 = WB_mux_writedata;
        else
            id_next.rdata1 = regs[rs];
        if (rt == 5'd0)
            id_next.rdata2 = '0;
        else if (wb_en && MEM_WB_rd == rt)
            id_next.rdata2 = WB_mux_writedata;
        else
            id_next.rdata2 = regs[rt];
    end

    logic [31:0] alu_a, alu_b, alu_y;

    assign alu_a = id_ex.rdata1;
    assign alu_b = id_ex.alusrc ? id_ex.sext : id_ex.rdata2;

    always_comb begin
        alu_y = '0;
        case (id_ex.aluop)
            2'b00: alu_y = alu_a + alu_b;
            2'b01: alu_y = alu_a - alu_b;
            2'b10: begin
                case (id_ex.sext[5:0])
                    6'h20: alu_y = alu_a + alu_b;
                    6'h22: alu_y = alu_a - alu_b;
                    6'h24: alu_y = alu_a & alu_b;
                    6'h25: alu_y = alu_a | alu_b;
                    6'h2A: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
                    default: alu_y = '0;
                endcase
            end
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        ex_next            = '0;
        ex_next.wb         = id_ex.wb;
        ex_next.branch     = id_ex.m[2];
        ex_next.memread    = id_ex.m[1];
        ex_next.memwrite   = id_ex.m[0];
        ex_next.zero       = (alu_y == 32'd0);
        ex_next.alu_result = alu_y;
        ex_next.rdata2     = id_ex.rdata2;
        ex_next.target     = id_ex.npc + id_ex.sext;
        ex_next.dest       = id_ex.regdst ? id_ex.rd : id_ex.rt;
    end

    logic [7:0] mem_addr;

    assign mem_addr = ex_mem.alu_result[7:0];

    always_comb begin
        wb_next            = '0;
        wb_next.regwrite   = ex_mem.wb[1];
        wb_next.memtoreg   = ex_mem.wb[0];
        wb_next.rdata      = ex_mem.memread ? dmem[mem_addr] : 32'd0;
        wb_next.alu_result = ex_mem.alu_result;
        wb_next.dest       = ex_mem.dest;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex  <= id_next;
            ex_mem <= ex_next;
            mem_wb <= wb_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            regs[MEM_WB_rd] <= WB_mux_writedata;
        end
    end

    // Data memory is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (ex_mem.memwrite)
            dmem[mem_addr] <= ex_mem.rdata2;
    end

    assign EX_MEM_PCSrc    = ex_mem.branch & ex_mem.zero;
    assign EX_MEM_NPC      = ex_mem.target;
    assign MEM_WB_regwrite = mem_wb.regwrite;
    assign MEM_WB_memtoreg = mem_wb.memtoreg;
    assign MEM_WB_rd       = mem_wb.dest;
    assign read_data       = mem_wb.rdata;
    assign mem_alu_result  = mem_wb.alu_result;

endmodule

// File: tb/tb_idecode_execute_memory.sv
// Directed bench for idecode_execute_memory with an external
// writeback mux model and an override for seeding registers.
module tb_idecode_execute_memory;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic [31:0] wb_data;
    logic        EX_MEM_PCSrc;
    logic [31:0] EX_MEM_NPC;
    logic        MEM_WB_regwrite;
    logic        MEM_WB_memtoreg;
    logic [4:0]  MEM_WB_rd;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;

    logic        ovr_en;
    logic [31:0] ovr_val;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign wb_data = ovr_en ? ovr_val
                   : (MEM_WB_memtoreg ? read_data : mem_alu_result);

    idecode_execute_memory dut (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_npc        (IF_ID_npc),
        .WB_mux_writedata (wb_data),
        .EX_MEM_PCSrc     (EX_MEM_PCSrc),
        .EX_MEM_NPC       (EX_MEM_NPC),
        .MEM_WB_regwrite  (MEM_WB_regwrite),
        .MEM_WB_memtoreg  (MEM_WB_memtoreg),
        .MEM_WB_rd        (MEM_WB_rd),
        .read_data        (read_data),
        .mem_alu_result   (mem_alu_result)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input logic [31:0] i, input logic [31:0] n);
        IF_ID_instr = i;
        IF_ID_npc   = n;
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [4:0] rd, input logic [31:0] v);
        tick({6'd0, 5'd0, 5'd0, rd, 5'd0, 6'h20}, 0);
        tick(NOP, 0);
        tick(NOP, 0);
        ovr_val = v;
        ovr_en  = 1'b1;
        tick(NOP, 0);
        ovr_en  = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " pcsrc"}, {31'd0, EX_MEM_PCSrc}, 0);
        chk({tag, " npc"}, EX_MEM_NPC, 0);
        chk({tag, " regwrite"}, {31'd0, MEM_WB_regwrite}, 0);
        chk({tag, " memtoreg"}, {31'd0, MEM_WB_memtoreg}, 0);
        chk({tag, " rd"}, {27'd0, MEM_WB_rd}, 0);
        chk({tag, " read_data"}, read_data, 0);
        chk({tag, " alu"}, mem_alu_result, 0);
    endtask

    initial begin
        vecs[0] = '{"add",   32'h0022_1820, 32'd12,        5'd3, 1'b1, 1'b0};
        vecs[1] = '{"sub",   32'h0022_1822, 32'hFFFF_FFFE, 5'd3, 1'b1, 1'b0};
        vecs[2] = '{"and",   32'h0022_1824, 32'd5,         5'd3, 1'b1, 1'b0};
        vecs[3] = '{"or",    32'h0022_1825, 32'd7,         5'd3, 1'b1, 1'b0};
        vecs[4] = '{"slt",   32'h0022_182A, 32'd1,         5'd3, 1'b1, 1'b0};
        vecs[5] = '{"sltr",  32'h0041_182A, 32'd0,         5'd3, 1'b1, 1'b0};
        vecs[6] = '{"badfn", 32'h0022_1827, 32'd0,         5'd3, 1'b1, 1'b0};
        vecs[7] = '{"add_r0",32'h0022_0020, 32'd12,        5'd0, 1'b1, 1'b0};

        ovr_en  = 1'b0;
        ovr_val = '0;
        rst     = 1'b1;
        tick(32'h0022_1820, 32'h55);
        tick(32'h8C04_0004, 32'h77);
        chk_zero("reset");
        rst = 1'b0;

        load_reg(5'd1, 32'd5);
        load_reg(5'd2, 32'd7);

        foreach (vecs[i]) begin
            tick(vecs[i].instr, 0);
            tick(NOP, 0);
            tick(NOP, 0);
            chk({vecs[i].name, " alu"}, mem_alu_result, vecs[i].alu);
            chk({vecs[i].name, " rd"}, {27'd0, MEM_WB_rd}, {27'd0, vecs[i].rd});
            chk({vecs[i].name, " rw"}, {31'd0, MEM_WB_regwrite}, {31'd0, vecs[i].rw});
            chk({vecs[i].name, " m2r"}, {31'd0, MEM_WB_memtoreg}, {31'd0, vecs[i].m2r});
        end

        // r0 write lands on the same edge r0 is read
        tick(32'h0000_1820, 0);
        tick(NOP, 0);
        tick(NOP, 0);
        chk("r0 read", mem_alu_result, 0);

        tick(32'hAC01_0004, 0);
        tick(32'h8C04_0004, 0);
        tick(NOP, 0);
        chk("sw regwrite", {31'd0, MEM_WB_regwrite}, 0);
        tick(NOP, 0);
        chk("lw data", read_data, 32'd5);
        chk("lw rd", {27'd0, MEM_WB_rd}, 32'd4);
        chk("lw m2r", {31'd0, MEM_WB_memtoreg}, 1);
        chk("lw rw", {31'd0, MEM_WB_regwrite}, 1);
        chk("lw addr", mem_alu_result, 32'd4);
        tick(NOP, 0);
        tick(32'h0080_2820, 0);
        tick(NOP, 0);
        tick(NOP, 0);
        chk("lw wb r4", mem_alu_result, 32'd5);

        tick(32'h1022_0003, 32'd10);
        tick(NOP, 0);
        chk("beq ne pcsrc", {31'd0, EX_MEM_PCSrc}, 0);
        chk("beq ne npc", EX_MEM_NPC, 32'd13);
        tick(NOP, 0);

        load_reg(5'd2, 32'd5);
        tick(32'h1022_0003, 32'd10);
        tick(NOP, 0);
        chk("beq eq pcsrc", {31'd0, EX_MEM_PCSrc}, 1);
        chk("beq eq npc", EX_MEM_NPC, 32'd13);
        tick(NOP, 0);
        chk("beq drop", {31'd0, EX_MEM_PCSrc}, 0);
        tick(32'h1022_FFFF, 32'd0);
        tick(NOP, 0);
        chk("beq wrap pcsrc", {31'd0, EX_MEM_PCSrc}, 1);
        chk("beq wrap npc", EX_MEM_NPC, 32'hFFFF_FFFF);
        tick(NOP, 0);
        tick(NOP, 0);

        tick(32'h0000_2820, 0);
        tick(NOP, 0);
        tick(NOP, 0);
        ovr_val = 32'h1234;
        ovr_en  = 1'b1;
        tick(32'h00A0_3020, 0);
        ovr_en  = 1'b0;
        tick(NOP, 0);
        tick(NOP, 0);
        chk("bypass rs", mem_alu_result, 32'h1234);
        chk("bypass rd", {27'd0, MEM_WB_rd}, 32'd6);

        tick(32'h0000_3820, 0);
        tick(NOP, 0);
        tick(NOP, 0);
        ovr_val = 32'hBEEF;
        ovr_en  = 1'b1;
        tick(32'h0007_4020, 0);
        ovr_en  = 1'b0;
        tick(NOP, 0);
        tick(NOP, 0);
        chk("bypass rt", mem_alu_result, 32'hBEEF);

        tick(32'hFC06_0004, 0);
        tick(NOP, 0);
        chk("unk pcsrc", {31'd0, EX_MEM_PCSrc}, 0);
        tick(NOP, 0);
        chk("unk rw", {31'd0, MEM_WB_regwrite}, 0);
        chk("unk m2r", {31'd0, MEM_WB_memtoreg}, 0);
        chk("unk rdata", read_data, 0);
        tick(32'h8C09_0004, 0);
        tick(NOP, 0);
        tick(NOP, 0);
        chk("unk no memwr", read_data, 32'd5);

        tick(32'h0022_1820, 0);
        tick(NOP, 0);
        rst = 1'b1;
        tick(NOP, 0);
        tick(NOP, 0);
        rst = 1'b0;
        chk_zero("midrst");
        tick(32'h0022_1820, 0);
        tick(NOP, 0);
        tick(NOP, 0);
        chk("rst regs", mem_alu_result, 0);
        tick(32'h8C04_0004, 0);
        tick(NOP, 0);
        tick(NOP, 0);
        chk("rst keeps mem", read_data, 32'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
